// File: rtl/mu_pool_force_if.sv
//------------------------------------------------------------------------------
// Module   : mu_pool_force_if
// Brief    : Spike-in / force-out bus of the motor-unit pool force block.
//            MP_EMG_EN adds the emg_out signal.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mu_pool_force_if #(
   parameter int NCH = 4,
   parameter int CW  = 16
);
   localparam int LG = $clog2(NCH);

   logic [NCH-1:0] spike_in;
   logic           tick;
   logic [15:0]    gain;
   logic [4:0]     tau_shift;
   logic [NCH-1:0] ch_enable;
   logic [LG-1:0]  act_sel;
   logic [31:0]    act_rd;
   logic [31:0]    force_out;
   logic           force_valid;
   logic           busy;
   logic           tick_overrun;
`ifdef MP_EMG_EN
   logic [CW+LG-1:0] emg_out;

   modport master (
      output spike_in, tick, gain, tau_shift, ch_enable, act_sel,
      input  act_rd, force_out, force_valid, busy, tick_overrun, emg_out
   );
   modport slave (
      input  spike_in, tick, gain, tau_shift, ch_enable, act_sel,
      output act_rd, force_out, force_valid, busy, tick_overrun, emg_out
   );
`else
   modport master (
      output spike_in, tick, gain, tau_shift, ch_enable, act_sel,
      input  act_rd, force_out, force_valid, busy, tick_overrun
   );
   modport slave (
      input  spike_in, tick, gain, tau_shift, ch_enable, act_sel,
      output act_rd, force_out, force_valid, busy, tick_overrun
   );
`endif

endinterface

`default_nettype wire

// File: rtl/mu_pool_force.sv
//------------------------------------------------------------------------------
// Module   : mu_pool_force
// Brief    : NCH motor-unit channels (spike count -> gain -> activation filter)
//            time-multiplexed onto one datapath; saturated total force per
//            window. Optional macro MP_EMG_EN adds the emg_out spike sum.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mu_pool_force #(
   parameter int NCH = 4,
   parameter int CW  = 16
) (
   input  wire logic       sim_clk,
   input  wire logic       reset_sim,
   mu_pool_force_if.slave  bus
);
   localparam int LG  = $clog2(NCH);
   localparam int ACW = 32 + LG;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UPD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [LG-1:0]   r_idx;
   logic [ACW-1:0]  r_acc;
   logic            r_pending;
   logic [31:0]     r_force;
   logic            r_force_valid;
   logic            r_busy;
   logic            r_overrun;
   logic [31:0]     r_act_rd;
   logic [CW-1:0]   r_cnt  [NCH];
   logic [CW-1:0]   r_snap [NCH];
   logic [31:0]     r_act  [NCH];

   logic               w_take_snap;
   logic               w_restart;
   logic [CW-1:0]      w_snap_cur;
   logic [31:0]        w_act_cur;
   logic [31:0]        w_prod;
   logic [31:0]        w_target;
   logic signed [32:0] w_diff;
   logic signed [32:0] w_step;
   logic signed [32:0] w_sum;
   logic [31:0]        w_act_new;

   // A tick landing on DONE is served exactly like a pending one.
   assign w_restart   = (r_state == DONE) && (r_pending || bus.tick);
   assign w_take_snap = ((r_state == IDLE) && bus.tick) || w_restart;

   assign w_snap_cur = r_snap[r_idx];
   assign w_act_cur  = r_act[r_idx];
   assign w_prod     = 32'(w_snap_cur) * 32'(bus.gain);
   assign w_target   = !bus.ch_enable[r_idx] ? 32'd0 :
                       (w_prod[31] ? 32'h7FFF_FFFF : w_prod);
   assign w_diff     = $signed({1'b0, w_target}) - $signed({1'b0, w_act_cur});
   assign w_step     = w_diff >>> bus.tau_shift;
   assign w_sum      = $signed({1'b0, w_act_cur}) + w_step;
   assign w_act_new  = w_sum[32] ? 32'd0 :
                       (w_sum[31] ? 32'h7FFF_FFFF : w_sum[31:0]);

   always_ff @(posedge sim_clk or posedge reset_sim) begin
      if (reset_sim) begin
         for (int i = 0; i < NCH; i++) begin
            r_cnt[i]  <= '0;
            r_snap[i] <= '0;
            r_act[i]  <= '0;
         end
         r_act_rd <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_take_snap) begin
               r_snap[i] <= r_cnt[i];
               r_cnt[i]  <= CW'(bus.spike_in[i]);
            end else if (bus.spike_in[i] && (r_cnt[i] != {CW{1'b1}})) begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
            if ((r_state == UPD) && (r_idx == LG'(i)))
               r_act[i] <= w_act_new;
         end
         r_act_rd <= r_act[bus.act_sel];
      end
   end

   always_ff @(posedge sim_clk or posedge reset_sim) begin
      if (reset_sim) begin
         r_state       <= IDLE;
         r_idx         <= '0;
         r_acc         <= '0;
         r_pending     <= 1'b0;
         r_force       <= '0;
         r_force_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_force_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.tick) begin
                  r_acc   <= '0;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= UPD;
               end
            end
            UPD: begin
               if (bus.tick) begin
                  if (r_pending) r_overrun <= 1'b1;
                  else           r_pending <= 1'b1;
               end
               r_acc <= r_acc + ACW'(w_act_new);
               r_idx <= r_idx + 1'b1;
               if (r_idx == LG'(NCH - 1))
                  r_state <= DONE;
            end
            DONE: begin
               r_force       <= (|r_acc[ACW-1:32]) ? 32'hFFFF_FFFF : r_acc[31:0];
               r_force_valid <= 1'b1;
               if (w_restart) begin
                  if (r_pending && bus.tick) r_overrun <= 1'b1;
                  r_pending <= 1'b0;
                  r_acc     <= '0;
                  r_idx     <= '0;
                  r_state   <= UPD;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef MP_EMG_EN
   localparam int EW = CW + LG;
   logic [EW-1:0] r_emg_acc;
   logic [EW-1:0] r_emg;

   always_ff @(posedge sim_clk or posedge reset_sim) begin
      if (reset_sim) begin
         r_emg_acc <= '0;
         r_emg     <= '0;
      end else begin
         if (r_state == DONE) r_emg <= r_emg_acc;
         if (w_take_snap)
            r_emg_acc <= '0;
         else if ((r_state == UPD) && bus.ch_enable[r_idx])
            r_emg_acc <= r_emg_acc + EW'(w_snap_cur);
      end
   end

   assign bus.emg_out = r_emg;
`endif

   assign bus.act_rd       = r_act_rd;
   assign bus.force_out    = r_force;
   assign bus.force_valid  = r_force_valid;
   assign bus.busy         = r_busy;
   assign bus.tick_overrun = r_overrun;

endmodule

`default_nettype wire
